// File: rtl/pkt_framer_pkg.sv
// Shared definitions for the packet framer and the downstream channel FSM:
// state encodings, default widths, header layout and beat-type flags.
package pkt_framer_pkg;

    localparam int unsigned PF_DATA_W      = 8;
    localparam int unsigned PF_LEN_W       = 4;
    localparam int unsigned PF_GAP_W       = 4;
    localparam int unsigned PF_FRAMES_W    = 16;
    // Header word carries the payload length starting at this bit.
    localparam int unsigned PF_HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_PAY  = 2'd1,
        PF_GAP  = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic valid;
        logic head;
        logic tail;
    } pf_beat_t;

    function automatic pf_beat_t pf_beat(input logic head, input logic tail);
        pf_beat_t b;
        b.valid = 1'b1;
        b.head  = head;
        b.tail  = tail;
        return b;
    endfunction

endpackage

// File: rtl/pf_gap_timer.sv
// Loadable down-counter that times the idle gap after each tail beat.
module pf_gap_timer
    import pkt_framer_pkg::*;
#(
    parameter int unsigned W = PF_GAP_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/pkt_framer.sv
// Frames a length request plus payload words into head/data/tail beats,
// with an optional forced idle gap after each tail. i_reset is active-low.
module pkt_framer
    import pkt_framer_pkg::*;
#(
    parameter int unsigned DATA_W = PF_DATA_W,
    parameter int unsigned LEN_W  = PF_LEN_W,
    parameter int unsigned GAP    = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req_valid,
    input  logic [LEN_W-1:0]       i_req_len,
    output logic                   o_req_ready,
    input  logic                   i_din_valid,
    input  logic [DATA_W-1:0]      i_din,
    output logic                   o_din_ready,
    output logic                   o_valid,
    output logic                   o_head,
    output logic                   o_tail,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_drop,
    output logic [PF_FRAMES_W-1:0] o_frames_sent
);

    localparam logic [PF_GAP_W-1:0] GAP_LOAD = PF_GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    pf_state_e               r_state, w_state_nxt;
    pf_beat_t                r_beat, w_beat_nxt;
    logic [DATA_W-1:0]       r_data, w_data_nxt;
    logic [LEN_W-1:0]        r_rem, w_rem_nxt;
    logic [PF_FRAMES_W-1:0]  r_frames_sent, w_frames_nxt;
    logic                    r_drop, w_drop_nxt;
    logic                    w_gap_load;
    logic                    w_gap_done;

    pf_gap_timer #(.W(PF_GAP_W)) u_gap_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_en       (r_state == PF_GAP),
        .o_done_c   (w_gap_done)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= PF_IDLE;
            r_beat        <= '0;
            r_data        <= '0;
            r_rem         <= '0;
            r_frames_sent <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_beat        <= w_beat_nxt;
            r_data        <= w_data_nxt;
            r_rem         <= w_rem_nxt;
            r_frames_sent <= w_frames_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    // Header is registered on the request accept, so there is no separate HDR cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = '0;
        w_data_nxt   = r_data;
        w_rem_nxt    = r_rem;
        w_frames_nxt = r_frames_sent;
        w_drop_nxt   = 1'b0;
        w_gap_load   = 1'b0;
        case (r_state)
            PF_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_len != '0) begin
                        w_rem_nxt   = i_req_len;
                        w_beat_nxt  = pf_beat(1'b1, 1'b0);
                        w_data_nxt  = DATA_W'(i_req_len) << PF_HDR_LEN_LSB;
                        w_state_nxt = PF_PAY;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
            end
            PF_PAY: begin
                if (i_din_valid) begin
                    w_data_nxt = i_din;
                    w_rem_nxt  = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_beat_nxt   = pf_beat(1'b0, 1'b1);
                        w_frames_nxt = r_frames_sent + PF_FRAMES_W'(1);
                        w_gap_load   = 1'b1;
                        w_state_nxt  = (GAP > 0) ? PF_GAP : PF_IDLE;
                    end else begin
                        w_beat_nxt   = pf_beat(1'b0, 1'b0);
                    end
                end
            end
            PF_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = PF_IDLE;
                end
            end
            default: begin
                w_state_nxt = PF_IDLE;
            end
        endcase
    end

    assign o_req_ready   = (r_state == PF_IDLE);
    assign o_din_ready   = (r_state == PF_PAY);
    assign o_valid       = r_beat.valid;
    assign o_head        = r_beat.head;
    assign o_tail        = r_beat.tail;
    assign o_data        = r_data;
    assign o_drop        = r_drop;
    assign o_frames_sent = r_frames_sent;

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer: one instance with no gap, one with a 2-cycle gap.
module tb_pkt_framer;

    logic        clk;
    logic        rst_n;

    logic        req_valid, din_valid;
    logic [3:0]  req_len;
    logic [7:0]  din;
    logic        req_ready, din_ready, valid, head, tail, drop;
    logic [7:0]  data;
    logic [15:0] frames;

    logic        g_req_valid, g_din_valid;
    logic [3:0]  g_req_len;
    logic [7:0]  g_din;
    logic        g_req_ready, g_din_ready, g_valid, g_head, g_tail, g_drop;
    logic [7:0]  g_data;
    logic [15:0] g_frames;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_framer #(.DATA_W(8), .LEN_W(4), .GAP(0)) dut0 (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .i_req_len(req_len), .o_req_ready(req_ready),
        .i_din_valid(din_valid), .i_din(din), .o_din_ready(din_ready),
        .o_valid(valid), .o_head(head), .o_tail(tail), .o_data(data),
        .o_drop(drop), .o_frames_sent(frames)
    );

    pkt_framer #(.DATA_W(8), .LEN_W(4), .GAP(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(g_req_valid), .i_req_len(g_req_len), .o_req_ready(g_req_ready),
        .i_din_valid(g_din_valid), .i_din(g_din), .o_din_ready(g_din_ready),
        .o_valid(g_valid), .o_head(g_head), .o_tail(g_tail), .o_data(g_data),
        .o_drop(g_drop), .o_frames_sent(g_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({valid, head, tail, drop, data, frames, req_ready, din_ready} !== {4'b0, 8'h00, 16'h0000, 2'b10}) begin
            n_fail++;
            $display("FAIL reset_dut0: got v%b h%b t%b d%b data=%h fr=%h rr%b dr%b, want all 0, rr1 dr0",
                     valid, head, tail, drop, data, frames, req_ready, din_ready);
        end
        n_checks++;
        if ({g_valid, g_head, g_tail, g_drop, g_data, g_frames, g_req_ready, g_din_ready} !== {4'b0, 8'h00, 16'h0000, 2'b10}) begin
            n_fail++;
            $display("FAIL reset_dut2: got v%b h%b t%b d%b data=%h fr=%h rr%b dr%b, want all 0, rr1 dr0",
                     g_valid, g_head, g_tail, g_drop, g_data, g_frames, g_req_ready, g_din_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [10:0] exp [4];
        exp[0] = {3'b110, 8'h03};
        exp[1] = {3'b100, 8'hA1};
        exp[2] = {3'b100, 8'hA2};
        exp[3] = {3'b101, 8'hA3};
        req_valid = 1'b1; req_len = 4'd3;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({valid, head, tail, data} !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got vht=%b%b%b data=%h, want %b data=%h",
                         i, valid, head, tail, data, exp[i][10:8], exp[i][7:0]);
            end
            if (i < 3) begin
                din_valid = 1'b1;
                din = 8'hA1 + 8'(i);
                step();
            end
        end
        din_valid = 1'b0;
        n_checks++;
        if (frames !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_frames: got %0d want 1", frames);
        end
        step();
        n_checks++;
        if ({valid, req_ready, din_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL basic_idle: got v%b rr%b dr%b want v0 rr1 dr0", valid, req_ready, din_ready);
        end
    endtask

    task automatic test_bubbles();
        req_valid = 1'b1; req_len = 4'd2;
        step();
        req_valid = 1'b0;
        din_valid = 1'b1; din = 8'h11;
        step();
        n_checks++;
        if ({valid, head, tail, data} !== {3'b100, 8'h11}) begin
            n_fail++;
            $display("FAIL bubble_word1: got vht=%b%b%b data=%h want 100 data=11", valid, head, tail, data);
        end
        din_valid = 1'b0; din = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({valid, head, tail, data, din_ready} !== {3'b000, 8'h11, 1'b1}) begin
                n_fail++;
                $display("FAIL bubble_gap%0d: got vht=%b%b%b data=%h dr%b want 000 data=11 dr1",
                         i, valid, head, tail, data, din_ready);
            end
        end
        din_valid = 1'b1; din = 8'h22;
        step();
        din_valid = 1'b0;
        n_checks++;
        if ({valid, head, tail, data, frames} !== {3'b101, 8'h22, 16'd2}) begin
            n_fail++;
            $display("FAIL bubble_tail: got vht=%b%b%b data=%h fr=%0d want 101 data=22 fr=2",
                     valid, head, tail, data, frames);
        end
        step();
    endtask

    task automatic test_zero_len();
        req_valid = 1'b1; req_len = 4'd0;
        step();
        n_checks++;
        if ({drop, valid, req_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL zero_drop: got drop%b v%b rr%b want drop1 v0 rr1", drop, valid, req_ready);
        end
        req_len = 4'd1;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({drop, valid, head, tail, data} !== {4'b0110, 8'h01}) begin
            n_fail++;
            $display("FAIL zero_next_head: got drop%b vht=%b%b%b data=%h want drop0 110 data=01",
                     drop, valid, head, tail, data);
        end
        din_valid = 1'b1; din = 8'h33;
        step();
        din_valid = 1'b0;
        n_checks++;
        if ({valid, head, tail, data, frames} !== {3'b101, 8'h33, 16'd3}) begin
            n_fail++;
            $display("FAIL zero_next_tail: got vht=%b%b%b data=%h fr=%0d want 101 data=33 fr=3",
                     valid, head, tail, data, frames);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp [4];
        exp[0] = {3'b110, 8'h01};
        exp[1] = {3'b101, 8'h44};
        exp[2] = {3'b110, 8'h01};
        exp[3] = {3'b101, 8'h55};
        req_valid = 1'b1; req_len = 4'd1;
        din_valid = 1'b1; din = 8'h44;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) din = 8'h55;
            if (i == 2) req_valid = 1'b0;
            if (i == 3) din_valid = 1'b0;
            n_checks++;
            if ({valid, head, tail, data} !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got vht=%b%b%b data=%h want %b data=%h",
                         i, valid, head, tail, data, exp[i][10:8], exp[i][7:0]);
            end
        end
        n_checks++;
        if (frames !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d want 5", frames);
        end
        step();
    endtask

    task automatic test_gap();
        logic [10:0] exp [8];
        exp[0] = {3'b110, 8'h01};
        exp[1] = {3'b101, 8'h71};
        exp[2] = {3'b000, 8'h71};
        exp[3] = {3'b000, 8'h71};
        exp[4] = {3'b110, 8'h01};
        exp[5] = {3'b101, 8'h72};
        exp[6] = {3'b000, 8'h72};
        exp[7] = {3'b000, 8'h72};
        g_req_valid = 1'b1; g_req_len = 4'd1;
        g_din_valid = 1'b1; g_din = 8'h71;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 1) g_din = 8'h72;
            if (i == 4) g_req_valid = 1'b0;
            n_checks++;
            if ({g_valid, g_head, g_tail, g_data} !== exp[i]) begin
                n_fail++;
                $display("FAIL gap_beat%0d: got vht=%b%b%b data=%h want %b data=%h",
                         i, g_valid, g_head, g_tail, g_data, exp[i][10:8], exp[i][7:0]);
            end
            if (i == 2) begin
                n_checks++;
                if ({g_req_ready, g_din_ready} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL gap_readies: got rr%b dr%b want rr0 dr0", g_req_ready, g_din_ready);
                end
            end
        end
        g_din_valid = 1'b0;
        n_checks++;
        if ({g_frames, g_req_ready} !== {16'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL gap_end: got fr=%0d rr%b want fr=2 rr1", g_frames, g_req_ready);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_len = 4'd5;
        step();
        req_valid = 1'b0;
        din_valid = 1'b1; din = 8'h61;
        step();
        din = 8'h62;
        step();
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, head, tail, data, frames} !== {3'b000, 8'h00, 16'h0000}) begin
            n_fail++;
            $display("FAIL midreset_async: got vht=%b%b%b data=%h fr=%0d want 000 data=00 fr=0",
                     valid, head, tail, data, frames);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({valid, tail, req_ready, din_ready, frames} !== {4'b0010, 16'h0000}) begin
            n_fail++;
            $display("FAIL midreset_after: got v%b t%b rr%b dr%b fr=%0d want v0 t0 rr1 dr0 fr=0",
                     valid, tail, req_ready, din_ready, frames);
        end
    endtask

    task automatic test_wrap_len15();
        force dut0.r_frames_sent = 16'hFFFF;
        #1;
        release dut0.r_frames_sent;
        #1;
        n_checks++;
        if (frames !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h want ffff", frames);
        end
        req_valid = 1'b1; req_len = 4'd15;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({valid, head, tail, data} !== {3'b110, 8'h0F}) begin
            n_fail++;
            $display("FAIL len15_head: got vht=%b%b%b data=%h want 110 data=0f", valid, head, tail, data);
        end
        for (int i = 1; i <= 15; i++) begin
            din_valid = 1'b1; din = 8'h80 + 8'(i);
            step();
            n_checks++;
            if ({valid, head, tail, data} !== {1'b1, 1'b0, (i == 15), 8'h80 + 8'(i)}) begin
                n_fail++;
                $display("FAIL len15_beat%0d: got vht=%b%b%b data=%h want 10%b data=%h",
                         i, valid, head, tail, data, (i == 15), 8'h80 + 8'(i));
            end
        end
        din_valid = 1'b0;
        n_checks++;
        if (frames !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_frames: got %h want 0000", frames);
        end
        step();
        n_checks++;
        if ({valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL len15_idle: got v%b rr%b want v0 rr1", valid, req_ready);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0; req_len = '0; din_valid = 1'b0; din = '0;
        g_req_valid = 1'b0; g_req_len = '0; g_din_valid = 1'b0; g_din = '0;
        test_reset();
        test_basic();
        test_bubbles();
        test_zero_len();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_wrap_len15();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_framer.md
# pkt_framer

Upstream packet source for the head/data/tail channel FSM. Takes a length request plus a stream of payload words and emits the framed beat stream (`valid`, `head`, `tail`, `data`) that the channel FSM decodes into IDLE → HEAD → DATA → TAIL. It guarantees the framing the consumer relies on:
- exactly one head beat per frame, then N payload beats;
- `tail` on the last payload beat only;
- `head` and `tail` never asserted on the same beat.

## Interface
Parameters:
- `DATA_W`, 8, width of `din`/`data`; must be ≥ `LEN_W`.
- `LEN_W`, 4, width of the payload length field.
- `GAP`, 0, idle cycles forced after each tail beat; range 0..15.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  frame request present.
- `req_len`  in  LEN_W  payload beat count for the request.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `din_valid`  in  1  payload word present.
- `din`  in  DATA_W  payload word.
- `din_ready`  out  1  payload word accepted when `din_valid & din_ready`.
- `valid`  out  1  beat qualifier to the channel FSM; registered.
- `head`  out  1  header beat; registered.
- `tail`  out  1  last payload beat; registered.
- `data`  out  DATA_W  beat data; registered.
- `drop`  out  1  one-cycle pulse: zero-length request discarded.
- `frames_sent`  out  16  count of completed tail beats; wraps at 2^16.

## Operation
States: IDLE, HDR, PAY, GAP.
- **IDLE**
  - `req_ready`=1, `din_ready`=0.
  - On accept with `req_len`≠0: latch `rem`=`req_len`, register header beat (`valid`=1, `head`=1, `data`=`req_len` zero-extended), go to PAY.
  - On accept with `req_len`=0: pulse `drop`, emit nothing, stay IDLE.
- **HDR** exists only as the registered-output cycle. It merges into the IDLE→PAY transition; no extra cycle.
- **PAY**
  - `req_ready`=0, `din_ready`=1.
  - Each accepted `din` registers a payload beat (`valid`=1, `head`=0, `data`=`din`) and decrements `rem`.
  - When `rem`=1 at accept: set `tail`=1, increment `frames_sent`, then go to GAP if `GAP`>0, else IDLE.
  - `din_valid`=0 → `valid`=0 bubble; state holds. The consumer stays in DATA.
- **GAP**
  - Both readies 0, outputs idle.
  - Counts `GAP` cycles, then goes to IDLE.
- Output flops default to `valid`=`head`=`tail`=0 on any cycle without a beat. `data` holds its last value when `valid`=0.
- `rem` is LEN_W bits and never underflows: PAY exits at `rem`=1.

## Timing
- Reset (`reset`=0, async): state=IDLE. `valid`=`head`=`tail`=`drop`=0, `data`=0, `frames_sent`=0, `rem`=0. Readies are combinational from state, so `req_ready`=1 and `din_ready`=0.
- Reset mid-frame: frame is abandoned immediately, with no tail emitted.
- Request accepted at edge N → header beat visible after edge N+1. First `din` can be accepted at edge N+1, so payload follows the header back-to-back.
- `din` accepted at edge M → beat visible after edge M+1 (1-cycle latency).
- With `GAP`=0: IDLE is re-entered the cycle after the tail accept. The next header appears the cycle after the tail beat, with no idle cycle in between. The consumer's TAIL→HEAD path covers this.
- With `GAP`=g: exactly g cycles with `valid`=0 between the tail beat and the next header.
- `req_len`=max (2^LEN_W−1) is legal; `frames_sent` wraps 0xFFFF→0x0000.

## Structure
- Shared package: state encodings (`PF_IDLE`, `PF_PAY`, `PF_GAP`), `LEN_W`/`DATA_W` defaults, and the header-word layout constant. The channel FSM uses the same beat-type definitions.
- One natural sub-module: `pf_gap_timer`, a loadable down-counter for the GAP state. Everything else stays in `pkt_framer`.

## Test plan
- **Basic frame:** `req_len`=3, din 0xA1,0xA2,0xA3 continuous → beats head(0x03), 0xA1, 0xA2, 0xA3+tail on consecutive cycles; `frames_sent`=1. Channel FSM walks HEAD, DATA, DATA, TAIL.
- **Bubbles:** `req_len`=2, `din_valid` low for 3 cycles between words → 3 `valid`=0 cycles mid-frame; tail only on the second word.
- **Zero length:** `req_len`=0 → `drop` high 1 cycle, `valid` never asserts, next request (len 1) framed normally: head(0x01), then data+tail.
- **Back-to-back:** two len-1 requests, `GAP`=0 → head, tail, head, tail on 4 consecutive cycles. With `GAP`=2 → exactly 2 idle cycles after each tail.
- **Reset mid-frame:** `reset`=0 during PAY of a len-5 frame after 2 words → outputs 0 asynchronously, no tail. After release, `req_ready`=1 and `frames_sent`=0.
- **Wrap:** preload via 65536 len-1 frames (or force) → `frames_sent` wraps to 0. Len-15 frame emits 15 payload beats with tail on the 15th.
